// File: rtl/riscv_pkg.sv
// Shared decode types for the RV32I write-back stage: base opcodes,
// write-back source selector and instruction field positions.
package riscv_pkg;

    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    localparam int RD_LSB  = 7;

    typedef enum logic [6:0] {
        OPC_OP_IMM = 7'b0010011,
        OPC_OP     = 7'b0110011,
        OPC_LOAD   = 7'b0000011,
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_STORE  = 7'b0100011,
        OPC_BRANCH = 7'b1100011,
        OPC_FENCE  = 7'b0001111,
        OPC_SYSTEM = 7'b1110011
    } opcode_t;

    typedef enum logic [2:0] {
        WB_NONE  = 3'd0,
        WB_I     = 3'd1,
        WB_R     = 3'd2,
        WB_LOAD  = 3'd3,
        WB_IMM   = 3'd4,
        WB_AUIPC = 3'd5,
        WB_LINK  = 3'd6
    } wb_sel_t;

    // Write-back source for an opcode; non-writing and unknown opcodes give WB_NONE.
    function automatic wb_sel_t decode_wb_sel(input logic [6:0] opc);
        wb_sel_t sel;
        case (opc)
            OPC_OP_IMM:        sel = WB_I;
            OPC_OP:            sel = WB_R;
            OPC_LOAD:          sel = WB_LOAD;
            OPC_LUI:           sel = WB_IMM;
            OPC_AUIPC:         sel = WB_AUIPC;
            OPC_JAL, OPC_JALR: sel = WB_LINK;
            default:           sel = WB_NONE;
        endcase
        return sel;
    endfunction

    // True for every opcode this core implements, writing or not.
    function automatic logic is_legal_opcode(input logic [6:0] opc);
        logic ok;
        case (opc)
            OPC_OP_IMM, OPC_OP, OPC_LOAD, OPC_LUI, OPC_AUIPC,
            OPC_JAL, OPC_JALR, OPC_STORE, OPC_BRANCH,
            OPC_FENCE, OPC_SYSTEM: ok = 1'b1;
            default:               ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// NREGS x XLEN register file: two asynchronous read ports, one write port
// committed on the rising edge, asynchronous clear, entry 0 reads as zero.
// No write-to-read bypass: a read in the write cycle sees the old value.
module regfile_2r1w #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            we,
    input  logic [AW-1:0]   wa,
    input  logic [XLEN-1:0] wd
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];

    // Next-state: apply the single write; entry 0 is never written.
    always_comb begin
        regs_d = regs_q;
        if (we && (wa != '0)) begin
            regs_d[wa] = wd;
        end
    end

    // Register storage with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read ports: index 0 is forced to zero regardless of storage.
    always_comb begin
        rd1 = (ra1 == '0) ? '0 : regs_q[ra1];
        rd2 = (ra2 == '0) ? '0 : regs_q[ra2];
    end

endmodule

// File: rtl/reg_writeback.sv
// Register file and write-back stage of the single-cycle RV32I core:
// instruction field decode, retire-value mux, cycle/instret counters and
// a sticky illegal-opcode flag.
//
// Handshake: instr_valid is a qualifier with no back-pressure; when high,
// idata and the operand buses describe one instruction that retires at the
// next rising edge. When low the cycle is a bubble: nothing is written and
// only cycle_cnt advances.
module reg_writeback
    import riscv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    input  logic [31:0]      idata,
    input  logic [XLEN-1:0]  imm,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  regdata_I,
    input  logic [XLEN-1:0]  regdata_R,
    input  logic [XLEN-1:0]  load_data,
    output logic [XLEN-1:0]  rv1,
    output logic [XLEN-1:0]  rv2,
    output logic [XLEN-1:0]  wb_data,
    output logic             wb_en,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt,
    output logic             illegal
);

    localparam int AW = $clog2(NREGS);

    logic [6:0]    opcode;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic [AW-1:0] rd;
    wb_sel_t       wb_sel;
    logic          legal;

    logic [CNT_W-1:0] cycle_q,   cycle_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             illegal_q, illegal_d;

    // funct3/funct7 belong to the execute units, not to write-back.
    logic unused_funct;
    assign unused_funct = ^{idata[31:25], idata[14:12]};

    // Field decode and write-back source selection.
    always_comb begin
        opcode = idata[6:0];
        rs1    = idata[RS1_LSB +: AW];
        rs2    = idata[RS2_LSB +: AW];
        rd     = idata[RD_LSB  +: AW];
        wb_sel = decode_wb_sel(opcode);
        legal  = is_legal_opcode(opcode);
    end

    // Retire-value mux; address arithmetic wraps modulo 2^XLEN.
    always_comb begin
        wb_en   = instr_valid && (wb_sel != WB_NONE) && (rd != '0);
        wb_data = '0;
        if (wb_en) begin
            case (wb_sel)
                WB_I:     wb_data = regdata_I;
                WB_R:     wb_data = regdata_R;
                WB_LOAD:  wb_data = load_data;
                WB_IMM:   wb_data = imm;
                WB_AUIPC: wb_data = pc + imm;
                WB_LINK:  wb_data = pc + XLEN'(4);
                default:  wb_data = '0;
            endcase
        end
    end

    // Counter and sticky-flag next state; counters wrap silently.
    always_comb begin
        cycle_d   = cycle_q + CNT_W'(1);
        instret_d = instret_q;
        illegal_d = illegal_q;
        if (instr_valid) begin
            if (legal) begin
                instret_d = instret_q + CNT_W'(1);
            end else begin
                illegal_d = 1'b1;
            end
        end
    end

    // Counters and illegal flag, asynchronously cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_q   <= '0;
            instret_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
            illegal_q <= illegal_d;
        end
    end

    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;
    assign illegal     = illegal_q;

    regfile_2r1w #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .AW    (AW)
    ) u_regfile (
        .clk (clk),
        .rst (rst),
        .ra1 (rs1),
        .ra2 (rs2),
        .rd1 (rv1),
        .rd2 (rv2),
        .we  (wb_en),
        .wa  (rd),
        .wd  (wb_data)
    );

endmodule

// File: tb/tb_reg_writeback.sv
// Bench for reg_writeback: fixed vector table, hand-written multi-cycle
// sequences (async reset, read-during-write, sticky illegal, bubbles) and
// randomized instructions checked against an architectural model.
module tb_reg_writeback;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic [31:0] idata = '0;
    logic [31:0] imm = '0;
    logic [31:0] pc = '0;
    logic [31:0] regdata_I = '0;
    logic [31:0] regdata_R = '0;
    logic [31:0] load_data = '0;
    logic [31:0] rv1, rv2, wb_data;
    logic        wb_en;
    logic [63:0] cycle_cnt, instret_cnt;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    // Architectural model state
    logic [31:0] m_regs [32];
    logic [63:0] m_cycle = '0;
    logic [63:0] m_instret = '0;
    logic        m_illegal = 1'b0;

    reg_writeback dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .idata       (idata),
        .imm         (imm),
        .pc          (pc),
        .regdata_I   (regdata_I),
        .regdata_R   (regdata_R),
        .load_data   (load_data),
        .rv1         (rv1),
        .rv2         (rv2),
        .wb_data     (wb_data),
        .wb_en       (wb_en),
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt),
        .illegal     (illegal)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // Cycle counter model: every rising edge outside reset.
    always @(posedge clk or posedge rst) begin
        if (rst) m_cycle <= '0;
        else     m_cycle <= m_cycle + 64'd1;
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd_f,
                                       input logic [4:0] rs1_f, input logic [4:0] rs2_f);
        return {7'b0, rs2_f, rs1_f, 3'b0, rd_f, op};
    endfunction

    // Architectural rule: what does this instruction retire?
    function automatic void model_wb(input logic v, input logic [31:0] ins, input logic [31:0] im,
                                     input logic [31:0] p, input logic [31:0] ri, input logic [31:0] rr,
                                     input logic [31:0] ld, output logic en, output logic [31:0] val,
                                     output logic lgl);
        logic        writes = 1'b1;
        logic [31:0] v_sel  = '0;
        lgl = 1'b1;
        case (ins[6:0])
            7'h13: v_sel = ri;
            7'h33: v_sel = rr;
            7'h03: v_sel = ld;
            7'h37: v_sel = im;
            7'h17: v_sel = p + im;
            7'h6F, 7'h67: v_sel = p + 32'd4;
            7'h23, 7'h63, 7'h0F, 7'h73: writes = 1'b0;
            default: begin writes = 1'b0; lgl = 1'b0; end
        endcase
        en  = v && writes && (ins[11:7] != 5'd0);
        val = en ? v_sel : 32'd0;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] idx);
        return (idx == 5'd0) ? 32'd0 : m_regs[idx];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_instret = '0;
        m_illegal = 1'b0;
    endtask

    // ---------------- driver ----------------
    // Drive one cycle, compare combinational outputs, clock it, compare state.
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] im,
                        input logic [31:0] p, input logic [31:0] ri, input logic [31:0] rr,
                        input logic [31:0] ld);
        logic        e_en, e_lgl;
        logic [31:0] e_val;
        instr_valid = v; idata = ins; imm = im; pc = p;
        regdata_I = ri; regdata_R = rr; load_data = ld;
        #1;
        model_wb(v, ins, im, p, ri, rr, ld, e_en, e_val, e_lgl);
        chk("wb_en", {63'd0, wb_en}, {63'd0, e_en});
        chk("wb_data", {32'd0, wb_data}, {32'd0, e_val});
        chk("rv1", {32'd0, rv1}, {32'd0, m_read(ins[19:15])});
        chk("rv2", {32'd0, rv2}, {32'd0, m_read(ins[24:20])});
        @(posedge clk);
        if (e_en) m_regs[ins[11:7]] = e_val;
        if (v && e_lgl)  m_instret = m_instret + 64'd1;
        if (v && !e_lgl) m_illegal = 1'b1;
        #1;
        chk("cycle_cnt", cycle_cnt, m_cycle);
        chk("instret_cnt", instret_cnt, m_instret);
        chk("illegal", {63'd0, illegal}, {63'd0, m_illegal});
    endtask

    task automatic idle();
        step(1'b0, '0, '0, '0, '0, '0, '0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        v;
        logic [6:0]  op;
        logic [4:0]  rd_f, rs1_f;
        logic [31:0] im, p, ri, rr, ld;
        logic        exp_en;
        logic [31:0] exp_data;
        logic [31:0] exp_rv1;
    } vec_t;

    vec_t vecs [10];

    localparam logic [6:0] OP_IMM = 7'h13, OP_R = 7'h33, OP_LD = 7'h03, OP_LUI = 7'h37,
                           OP_AUIPC = 7'h17, OP_JAL = 7'h6F, OP_JALR = 7'h67, OP_ST = 7'h23,
                           OP_BR = 7'h63;

    // ---------------- scoreboard for random traffic ----------------
    logic [31:0] exp_q [$];

    initial begin
        logic [31:0] ins;
        logic [6:0]  ops [12];
        logic [63:0] hold_instret;

        vecs[0] = '{1'b1, OP_IMM,   5'd3,  5'd0,  32'hFFFFFFFF, 32'h0,        32'hFFFFFFFF, 32'h0,    32'h0,        1'b1, 32'hFFFFFFFF, 32'h0};
        vecs[1] = '{1'b1, OP_R,     5'd4,  5'd3,  32'h0,        32'h0,        32'h0,        32'hA5A5, 32'h0,        1'b1, 32'h0000A5A5, 32'hFFFFFFFF};
        vecs[2] = '{1'b1, OP_LUI,   5'd0,  5'd0,  32'hABCDE000, 32'h0,        32'h0,        32'h0,    32'h0,        1'b0, 32'h0,        32'h0};
        vecs[3] = '{1'b1, OP_JAL,   5'd1,  5'd4,  32'h0,        32'hFFFFFFFC, 32'h0,        32'h0,    32'h0,        1'b1, 32'h0,        32'h0000A5A5};
        vecs[4] = '{1'b1, OP_AUIPC, 5'd2,  5'd1,  32'h1000,     32'h100,      32'h0,        32'h0,    32'h0,        1'b1, 32'h1100,     32'h0};
        vecs[5] = '{1'b1, OP_R,     5'd8,  5'd2,  32'h0,        32'h0,        32'h0,        32'h7,    32'h0,        1'b1, 32'h7,        32'h1100};
        vecs[6] = '{1'b1, OP_LD,    5'd9,  5'd3,  32'h0,        32'h0,        32'h0,        32'h0,    32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 32'hFFFFFFFF};
        vecs[7] = '{1'b1, OP_JALR,  5'd10, 5'd9,  32'h0,        32'h200,      32'h0,        32'h0,    32'h0,        1'b1, 32'h204,      32'hDEADBEEF};
        vecs[8] = '{1'b1, OP_ST,    5'd5,  5'd10, 32'h0,        32'h0,        32'h0,        32'h0,    32'h0,        1'b0, 32'h0,        32'h204};
        vecs[9] = '{1'b0, OP_IMM,   5'd11, 5'd4,  32'h0,        32'h0,        32'h1,        32'h0,    32'h0,        1'b0, 32'h0,        32'h0000A5A5};

        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        #1;
        chk("reset_cycle", cycle_cnt, 64'd0);
        chk("reset_instret", instret_cnt, 64'd0);
        chk("reset_illegal", {63'd0, illegal}, 64'd0);
        chk("reset_rv1", {32'd0, rv1}, 64'd0);

        // Table-driven vectors from a clean register file
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            instr_valid = vecs[i].v;
            idata = mk(vecs[i].op, vecs[i].rd_f, vecs[i].rs1_f, vecs[i].rd_f);
            imm = vecs[i].im; pc = vecs[i].p; regdata_I = vecs[i].ri;
            regdata_R = vecs[i].rr; load_data = vecs[i].ld;
            #1;
            chk($sformatf("vec%0d_wb_en", i), {63'd0, wb_en}, {63'd0, vecs[i].exp_en});
            chk($sformatf("vec%0d_wb_data", i), {32'd0, wb_data}, {32'd0, vecs[i].exp_data});
            chk($sformatf("vec%0d_rv1", i), {32'd0, rv1}, {32'd0, vecs[i].exp_rv1});
            step(vecs[i].v, idata, imm, pc, regdata_I, regdata_R, load_data);
            if (i == 0) chk("addi_instret", instret_cnt, 64'd1);
        end
        chk("table_instret", instret_cnt, 64'd9);

        // Read-during-write: old value this cycle, new value next
        @(negedge clk);
        step(1'b1, mk(OP_IMM, 5'd7, 5'd0, 5'd0), '0, '0, 32'd5, '0, '0);
        @(negedge clk);
        instr_valid = 1'b1; idata = mk(OP_IMM, 5'd7, 5'd7, 5'd7); regdata_I = 32'd9;
        #1;
        chk("rdw_old_rv1", {32'd0, rv1}, 64'd5);
        chk("rdw_old_rv2", {32'd0, rv2}, 64'd5);
        step(1'b1, idata, '0, '0, 32'd9, '0, '0);
        instr_valid = 1'b0; idata = mk(OP_ST, 5'd0, 5'd7, 5'd0);
        #1;
        chk("rdw_new_rv1", {32'd0, rv1}, 64'd9);

        // Illegal opcode is sticky, writes nothing, does not retire
        @(negedge clk);
        hold_instret = m_instret;
        step(1'b1, mk(7'h7F, 5'd12, 5'd0, 5'd0), '0, '0, 32'h55, 32'h55, 32'h55);
        chk("illegal_set", {63'd0, illegal}, 64'd1);
        chk("illegal_instret_held", instret_cnt, hold_instret);
        step(1'b1, mk(OP_IMM, 5'd13, 5'd12, 5'd0), '0, '0, 32'h77, '0, '0);
        chk("illegal_sticky", {63'd0, illegal}, 64'd1);
        chk("illegal_no_write", {32'd0, rv1}, 64'd0);

        // Bubbles carrying store/branch: only cycle_cnt moves
        hold_instret = m_instret;
        step(1'b0, mk(OP_ST, 5'd14, 5'd13, 5'd7), '0, '0, '0, '0, '0);
        step(1'b0, mk(OP_BR, 5'd15, 5'd13, 5'd7), '0, '0, '0, '0, '0);
        chk("bubble_instret", instret_cnt, hold_instret);

        // Reset mid-cycle: clears at once and drops the pending write
        @(negedge clk);
        step(1'b1, mk(OP_IMM, 5'd5, 5'd0, 5'd0), '0, '0, 32'h1234, '0, '0);
        instr_valid = 1'b1; idata = mk(OP_IMM, 5'd6, 5'd5, 5'd0); regdata_I = 32'hCAFE;
        #1;
        chk("pre_rst_x5", {32'd0, rv1}, 64'h1234);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("rst_x5_immediate", {32'd0, rv1}, 64'd0);
        chk("rst_cycle", cycle_cnt, 64'd0);
        chk("rst_instret", instret_cnt, 64'd0);
        chk("rst_illegal", {63'd0, illegal}, 64'd0);
        @(negedge clk) rst = 1'b0;
        idata = mk(OP_ST, 5'd0, 5'd6, 5'd5); instr_valid = 1'b0;
        #1;
        chk("rst_write_lost", {32'd0, rv1}, 64'd0);

        // Randomized instructions with scoreboarded register read-back
        ops = '{OP_IMM, OP_R, OP_LD, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_ST, OP_BR, 7'h0F, 7'h73, 7'h0B};
        for (int n = 0; n < 300; n++) begin
            ins = mk(ops[$urandom_range(0, 11)], 5'($urandom_range(0, 31)),
                     5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            if (n < 200 && ins[6:0] == 7'h0B) ins[6:0] = OP_IMM;
            step($urandom_range(0, 4) != 0, ins, $urandom, $urandom, $urandom, $urandom, $urandom);
        end

        // Scoreboard sweep: every register against the model
        for (int r = 0; r < 32; r++) exp_q.push_back(m_read(5'(r)));
        for (int r = 0; r < 32; r++) begin
            instr_valid = 1'b0; idata = mk(OP_ST, 5'd0, 5'(r), 5'(r));
            #1;
            chk($sformatf("sweep_x%0d", r), {32'd0, rv1}, {32'd0, exp_q.pop_front()});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
